// File: rtl/fifo_util_pkg.sv
// rtl/fifo_util_pkg.sv - shared sizing helpers for bootloader buffers
package fifo_util_pkg;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Output buffer must cover every read in flight plus one word being popped.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

    function automatic int level_width(input int ram_size, input int rd_latency);
        return ceil_log2(ram_size + buf_depth(rd_latency) + 1);
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - producer, RAM and consumer signals of the RAM FIFO controller
interface ram_fifo_ctrl_if #(
    parameter int AW         = 10,
    parameter int DATA_WIDTH = 8,
    parameter int LW         = 11
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  ram_we_o;
    logic [AW-1:0]         ram_waddr_o;
    logic                  ram_re_o;
    logic [AW-1:0]         ram_raddr_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [LW-1:0]         level_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;

    modport master (
        output in_valid_i, ram_rdata_i, out_ready_i,
        input  in_ready_o, ram_we_o, ram_waddr_o, ram_re_o, ram_raddr_o,
        input  out_valid_o, out_data_o, level_o, empty_o, full_o,
        input  almost_full_o, almost_empty_o
    );

    modport slave (
        input  in_valid_i, ram_rdata_i, out_ready_i,
        output in_ready_o, ram_we_o, ram_waddr_o, ram_re_o, ram_raddr_o,
        output out_valid_o, out_data_o, level_o, empty_o, full_o,
        output almost_full_o, almost_empty_o
    );
endinterface

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - small register FIFO holding returned RAM words; head stays put until popped
module fifo_out_buf
    import fifo_util_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter int  WIDTH = 8,
    localparam int IW    = ceil_log2(DEPTH),
    localparam int CW    = ceil_log2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            count_o <= '0;
        end else if (clr_i) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) wr_idx <= idx_next(wr_idx);
            if (pop_i)  rd_idx <= idx_next(rd_idx);
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_idx] <= data_i;
    end

    assign data_o = mem[rd_idx];
endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - turns a synchronous 1W/1R RAM into a FIFO with credit-limited reads and fill flags
module ram_fifo_ctrl
    import fifo_util_pkg::*;
#(
    parameter int  RAM_SIZE   = 1024,
    parameter int  DATA_WIDTH = 8,
    parameter int  RD_LATENCY = 1,
    parameter int  AFULL_TH   = 1020,
    parameter int  AEMPTY_TH  = 4,
    localparam int AW         = ceil_log2(RAM_SIZE),
    localparam int BUF        = buf_depth(RD_LATENCY),
    localparam int LW         = level_width(RAM_SIZE, RD_LATENCY),
    localparam int BW         = ceil_log2(BUF + 1)
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            en_i,
    ram_fifo_ctrl_if.slave  bus
);
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [LW-1:0]         ram_cnt;
    logic [BW-1:0]         inflight_cnt;
    logic [BW-1:0]         buf_cnt;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [RD_LATENCY-1:0] vld_next;
    logic                  full;
    logic                  ram_we;
    logic                  ram_re;
    logic                  arrive;
    logic                  pop;
    logic                  out_valid;
    logic [LW-1:0]         level;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(RAM_SIZE - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full   = (ram_cnt == LW'(RAM_SIZE));
    assign ram_we = bus.in_valid_i & en_i & ~full;
    // Read issue depends only on registered state, so a word written this cycle is read next cycle at the earliest.
    assign ram_re = en_i & (ram_cnt != '0) &
                    (({1'b0, inflight_cnt} + {1'b0, buf_cnt}) < (BW + 1)'(BUF));
    assign arrive    = vld_sr[RD_LATENCY-1];
    assign out_valid = (buf_cnt != '0);
    assign pop       = out_valid & bus.out_ready_i;
    assign level     = ram_cnt + LW'(inflight_cnt) + LW'(buf_cnt);

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign vld_next = ram_re;
        end else begin : g_latn
            assign vld_next = {vld_sr[RD_LATENCY-2:0], ram_re};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr         <= '0;
            rptr         <= '0;
            ram_cnt      <= '0;
            inflight_cnt <= '0;
            vld_sr       <= '0;
        end else if (!en_i) begin
            wptr         <= '0;
            rptr         <= '0;
            ram_cnt      <= '0;
            inflight_cnt <= '0;
            vld_sr       <= '0;
        end else begin
            if (ram_we) wptr <= ptr_next(wptr);
            if (ram_re) rptr <= ptr_next(rptr);
            ram_cnt      <= ram_cnt + LW'(ram_we) - LW'(ram_re);
            inflight_cnt <= inflight_cnt + BW'(ram_re) - BW'(arrive);
            vld_sr       <= vld_next;
        end
    end

    fifo_out_buf #(
        .DEPTH (BUF),
        .WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (~en_i),
        .push_i  (arrive),
        .data_i  (bus.ram_rdata_i),
        .pop_i   (pop),
        .data_o  (bus.out_data_o),
        .count_o (buf_cnt)
    );

    assign bus.in_ready_o     = en_i & ~full;
    assign bus.ram_we_o       = ram_we;
    assign bus.ram_waddr_o    = wptr;
    assign bus.ram_re_o       = ram_re;
    assign bus.ram_raddr_o    = rptr;
    assign bus.out_valid_o    = out_valid;
    assign bus.level_o        = level;
    assign bus.empty_o        = (level == '0);
    assign bus.full_o         = full;
    assign bus.almost_full_o  = int'(level) >= AFULL_TH;
    assign bus.almost_empty_o = int'(level) <= AEMPTY_TH;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl with a behavioural RAM and occupancy model
module tb_ram_fifo_ctrl;
    import fifo_util_pkg::*;

    localparam int RAM_SIZE = 5;
    localparam int DW       = 8;
    localparam int RL       = 2;
    localparam int AF       = 6;
    localparam int AE       = 2;
    localparam int AW       = ceil_log2(RAM_SIZE);
    localparam int BUF      = buf_depth(RL);
    localparam int LW       = level_width(RAM_SIZE, RL);
    localparam int CAP      = RAM_SIZE + BUF;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b1;
    logic [DW-1:0] wdata = '0;
    int            total = 0;
    int            bad = 0;

    ram_fifo_ctrl_if #(.AW(AW), .DATA_WIDTH(DW), .LW(LW)) bus ();

    ram_fifo_ctrl #(
        .RAM_SIZE(RAM_SIZE), .DATA_WIDTH(DW), .RD_LATENCY(RL),
        .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .en_i   (en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [RAM_SIZE];
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd2 = '0;
    always @(posedge clk) begin
        if (bus.ram_we_o) mem[bus.ram_waddr_o] <= wdata;
        if (bus.ram_re_o) rd1 <= mem[bus.ram_raddr_o];
        rd2 <= rd1;
    end
    assign bus.ram_rdata_i = (RL == 2) ? rd2 : rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is simply accepted minus popped words, cleared by en/reset.
    logic [DW-1:0] exp_q[$];
    int            level_m = 0;
    int            waddr_m = 0;
    int            pops_total = 0;
    bit            hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            level_m = 0; waddr_m = 0; hold_v = 1'b0; exp_q.delete();
        end else begin
            bit acc, pp;
            chk("level", bus.level_o, level_m);
            chk("empty", bus.empty_o, level_m == 0);
            chk("almost_full", bus.almost_full_o, level_m >= AF);
            chk("almost_empty", bus.almost_empty_o, level_m <= AE);
            if (!en) chk("in_ready_disabled", bus.in_ready_o, 0);
            acc = bus.in_valid_i & bus.in_ready_o;
            chk("ram_we", bus.ram_we_o, acc);
            if (hold_v) begin
                chk("stable_valid", bus.out_valid_o, 1);
                chk("stable_data", bus.out_data_o, hold_d);
            end
            if (acc) begin
                chk("waddr", bus.ram_waddr_o, waddr_m);
                exp_q.push_back(wdata);
                waddr_m = (waddr_m + 1) % RAM_SIZE;
            end
            pp = bus.out_valid_o & bus.out_ready_i;
            if (pp) begin
                chk("pop_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("out_data", bus.out_data_o, exp_q.pop_front());
                pops_total++;
            end
            level_m = level_m + int'(acc) - int'(pp);
            hold_v  = bus.out_valid_o & ~bus.out_ready_i & en;
            hold_d  = bus.out_data_o;
            if (!en) begin
                level_m = 0; waddr_m = 0; hold_v = 1'b0; exp_q.delete();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b1;
        wdata = d;
        for (int b = 0; b < 100; b++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("send_timeout", ok, 1);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.empty_o && exp_q.size() == 0) begin done = 1'b1; break; end
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sent, got, first, last, lastsend, p0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;

        #2;
        chk("rst_in_ready", bus.in_ready_o, 1);
        chk("rst_ram_re", bus.ram_re_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_full", bus.full_o, 0);
        chk("rst_afull", bus.almost_full_o, 0);
        chk("rst_aempty", bus.almost_empty_o, 1);
        chk("rst_waddr", bus.ram_waddr_o, 0);
        chk("rst_raddr", bus.ram_raddr_o, 0);
        bus.in_valid_i = 1'b1; #1;
        chk("rst_ram_we", bus.ram_we_o, 1);
        bus.in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Fill to full with consumer stalled
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            bus.in_valid_i = (n < 10);
            wdata = DW'(n + 1);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) n++;
        end
        idle(1);
        @(negedge clk);
        chk("fill_accepted", n, CAP);
        chk("fill_full", bus.full_o, 1);
        chk("fill_in_ready", bus.in_ready_o, 0);
        chk("fill_level", bus.level_o, CAP);
        drain(40);

        // First-word latency
        bus.out_ready_i = 1'b0;
        idle(2);
        send(8'hA5);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        for (int k = 1; k <= RL + 2; k++) begin
            @(negedge clk);
            chk("lat_ram_re", bus.ram_re_o, k == 1);
            chk("lat_out_valid", bus.out_valid_o, k == RL + 2);
            if (k < RL + 2) @(posedge clk);
        end
        drain(20);

        // Wrap and sustained throughput
        sent = 0; got = 0; first = -1; last = -1; lastsend = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            bus.in_valid_i = (sent < 20);
            wdata = DW'($urandom);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) begin sent++; lastsend = c; end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (first < 0) first = c;
                last = c; got++;
            end
        end
        chk("stream_sent", sent, 20);
        chk("stream_in_nogap", lastsend, 19);
        chk("stream_got", got, 20);
        chk("stream_out_nogap", last - first, 19);

        // Random backpressure
        sent = 0; p0 = pops_total;
        for (int c = 0; c < 8000 && sent < 1000; c++) begin
            @(posedge clk); #1;
            bus.in_valid_i  = ($urandom_range(3) != 0);
            wdata           = DW'($urandom);
            bus.out_ready_i = $urandom_range(1);
            @(negedge clk);
            if (bus.in_valid_i && bus.in_ready_o) sent++;
        end
        drain(100);
        chk("bp_sent", sent, 1000);
        chk("bp_popped", pops_total - p0, 1000);

        // Clear mid-stream with reads in flight
        repeat (4) send(DW'($urandom));
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("clr_level", bus.level_o, 0);
        chk("clr_out_valid", bus.out_valid_o, 0);
        chk("clr_waddr", bus.ram_waddr_o, 0);
        repeat (3) send(DW'($urandom));
        drain(20);

        // Thresholds, one word at a time
        bus.out_ready_i = 1'b0;
        for (int i = 1; i <= CAP; i++) begin
            send(DW'(8'h40 + i));
            idle(3);
            @(negedge clk);
            chk("th_level", bus.level_o, i);
            chk("th_aempty", bus.almost_empty_o, i <= AE);
            chk("th_afull", bus.almost_full_o, i >= AF);
        end

        // Asynchronous reset while full
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("arst_level", bus.level_o, 0);
        chk("arst_out_valid", bus.out_valid_o, 0);
        chk("arst_full", bus.full_o, 0);
        chk("arst_empty", bus.empty_o, 1);
        chk("arst_waddr", bus.ram_waddr_o, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        send(8'h3C);
        send(8'hC3);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
